neo_lb_mixer: RTL and testbench
===============================

Name: neo_lb_mixer

Overview:
- Parametrised sprite line-buffer pair plus palette-address mixer for the video path.
- Sprite pixels for the next line are written into one bank while the other bank is scanned out, overlaid with fix pixels, blanked and arbitrated against CPU palette access.
- New over the fixed-size predecessor: parametrised widths and depth, write-direction (H-flip) counter, transparent-pixel skip, optional clear-on-read, and a post-reset zeroing sweep with a READY flag.

Parameters:
- ADDR_W, 9: line-buffer address width; each bank holds 2^ADDR_W pixels.
- PAL_W, 8: sprite palette number width.
- COLOR_W, 4: pixel colour index width.
- FIX_PAL_W, 4: fix palette number width; must be ≤ PAL_W.
- CLEAR_ON_READ, 1: 1 = zero each entry as it is scanned out.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-high reset.
- CLK_EN_PIX  in  1  pixel enable, one CLK wide; consecutive pulses are ≥2 CLK apart.
- TMS  in  1  bank select: bank TMS is read, bank ~TMS is written.
- WR_LD  in  1  load write pointer from WR_ADDR.
- WR_ADDR  in  ADDR_W  write start address.
- WR_DIR  in  1  0 = increment after each write, 1 = decrement.
- WR_EN  in  1  write strobe, one pixel per CLK.
- WR_PAL  in  PAL_W  sprite palette.
- WR_COLOR  in  COLOR_W  sprite colour; 0 = transparent.
- RD_LD  in  1  load read pointer from RD_ADDR.
- RD_ADDR  in  ADDR_W  scan start address.
- RD_RUN  in  1  scan active.
- FIX_COLOR  in  COLOR_W  fix pixel colour, aligned to the output stage.
- FIX_PAL  in  FIX_PAL_W  fix palette.
- FIX_EN  in  1  fix layer enable.
- BLANK  in  1  force video address to 0.
- CPU_SEL  in  1  CPU owns the palette bus.
- CPU_ADDR  in  PAL_W+COLOR_W  CPU palette address.
- PA  out  PAL_W+COLOR_W  palette address bus.
- READY  out  1  initialisation sweep complete.

Behaviour:
- Reset:
  - wr_ptr = 0, rd_ptr = 0, PA_VIDEO = 0, READY = 0, state = INIT, sweep counter = 0.
  - PA = CPU_SEL ? CPU_ADDR : 0.
- State machine:
  - INIT: each CLK writes 0 to the same address in both banks, then counter+1. After address 2^ADDR_W−1 is written, go to RUN and set READY=1 on the next CLK.
  - In INIT: WR_EN, RD_RUN, WR_LD and RD_LD are ignored; PA_VIDEO is held at 0.
  - RUN: stays in RUN until RST.
- Write port (RUN):
  - WR_LD has priority over WR_EN. When both are asserted, the pointer loads and nothing is written.
  - On WR_EN: if WR_COLOR ≠ 0, write {WR_PAL, WR_COLOR} to bank ~TMS at wr_ptr.
  - wr_ptr then steps ±1 per WR_DIR, whether or not the write happened.
  - wr_ptr wraps modulo 2^ADDR_W in both directions (0 − 1 = 2^ADDR_W−1).
- Read port (RUN), on a CLK_EN_PIX pulse:
  - If RD_LD: rd_ptr ← RD_ADDR and no read occurs. RD_LD outside a pulse also loads.
  - Else if RD_RUN: read bank TMS at rd_ptr, then rd_ptr+1 with wrap.
  - If CLEAR_ON_READ=1, the same entry is written to 0 in that cycle. The RAM is read-first, so the old data is returned.
- Output stage, on each CLK_EN_PIX, PA_VIDEO is registered from:
  - BLANK → 0.
  - Else FIX_EN & FIX_COLOR ≠ 0 → {zeros, FIX_PAL, FIX_COLOR}.
  - Else the RAM data read at the previous pulse, or 0 if that pulse performed no read.
- Latency: a pixel read at pulse n appears on PA after pulse n+1, i.e. 2 pixel pulses after RD_LD plus one RD_RUN pulse.
- PA = CPU_SEL ? CPU_ADDR : PA_VIDEO. This is combinational and does not disturb PA_VIDEO.
- TMS toggle:
  - Takes effect for both ports from the next CLK.
  - RAM data already read is still delivered.
  - Pointers are not reset.
- Port collision is impossible because the two ports always address different banks.
- RST mid-line: all state returns to reset values and INIT re-runs, so both banks end up zeroed.

Decomposition:
- Shared package neo_lb_pkg:
  - state type {INIT, RUN}.
  - PA_W = PAL_W+COLOR_W.
  - pixel record/struct {pal, color}.
- Sub-module lb_bank_ram:
  - single-port, read-first synchronous RAM, 2^ADDR_W × PA_W, with write enable.
  - Instantiated twice, once per bank.
- Address/write-enable muxing and all control stay in neo_lb_mixer.

Test Plan:
- Init sweep: release RST, ADDR_W=9 → READY rises 513 CLK later (512 sweep writes plus the READY register). Afterwards every address of both banks reads 0; PA=0 throughout.
- Write and scan: TMS=0, WR_LD addr 0x010, WR_DIR=0, 4 writes pal=0x3A colours 1,0,5,F → bank 1 holds 0x3A1, 0, 0x3A5, 0x3AF at 0x010–0x013. Set TMS=1, RD_LD 0x010, RD_RUN → PA sequence 0x3A1, 0x000, 0x3A5, 0x3AF; the 0x011 entry was never written.
- H-flip wrap: WR_LD 0x001, WR_DIR=1, 3 opaque writes → entries at 0x001, 0x000, 0x1FF; wr_ptr ends at 0x1FE.
- Clear-on-read: after the scan above, rescan the same range → PA all 0. With CLEAR_ON_READ=0 → the same non-zero values repeat.
- Priority: sprite 0x3A5 under FIX_EN, fix colour 7, FIX_PAL 2 → PA 0x027. With BLANK=1 → 0x000. With CPU_SEL=1, CPU_ADDR 0xABC → PA 0xABC immediately; on deassert PA returns to the current PA_VIDEO.
- Reset mid-scan: assert RST during a scan → PA 0 and READY 0 at once; after re-init, a scan of the previously written range returns 0.

Source files
------------

// File: rtl/neo_lb_pkg.sv
// Shared types for the sprite line-buffer mixer: FSM state, pixel record
// and the palette-address width helper.
package neo_lb_pkg;

  typedef enum logic {INIT, RUN} lb_state_t;

  localparam int PAL_W_DEF   = 8;
  localparam int COLOR_W_DEF = 4;
  localparam int PA_W        = PAL_W_DEF + COLOR_W_DEF;

  typedef struct packed {
    logic [PAL_W_DEF-1:0]   pal;
    logic [COLOR_W_DEF-1:0] color;
  } pixel_t;

  function automatic int pa_width(input int pal_w, input int color_w);
    return pal_w + color_w;
  endfunction

endpackage

// File: rtl/lb_bank_ram.sv
// One line-buffer bank: single-port synchronous RAM, read-first, with a
// separate read enable so writes never disturb data already fetched.
module lb_bank_ram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (rd_en) rdata <= mem[addr];
    if (we)    mem[addr] <= wdata;
  end

endmodule

// File: rtl/neo_lb_mixer.sv
// Double-buffered sprite line buffer with fix overlay, blanking and CPU
// palette arbitration; zeroes both banks after reset before raising READY.
module neo_lb_mixer
  import neo_lb_pkg::*;
#(
  parameter int ADDR_W        = 9,
  parameter int PAL_W         = 8,
  parameter int COLOR_W       = 4,
  parameter int FIX_PAL_W     = 4,
  parameter int CLEAR_ON_READ = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CLK_EN_PIX,
  input  logic                     TMS,
  input  logic                     WR_LD,
  input  logic [ADDR_W-1:0]        WR_ADDR,
  input  logic                     WR_DIR,
  input  logic                     WR_EN,
  input  logic [PAL_W-1:0]         WR_PAL,
  input  logic [COLOR_W-1:0]       WR_COLOR,
  input  logic                     RD_LD,
  input  logic [ADDR_W-1:0]        RD_ADDR,
  input  logic                     RD_RUN,
  input  logic [COLOR_W-1:0]       FIX_COLOR,
  input  logic [FIX_PAL_W-1:0]     FIX_PAL,
  input  logic                     FIX_EN,
  input  logic                     BLANK,
  input  logic                     CPU_SEL,
  input  logic [PAL_W+COLOR_W-1:0] CPU_ADDR,
  output logic [PAL_W+COLOR_W-1:0] PA,
  output logic                     READY
);

  localparam int PIX_W = pa_width(PAL_W, COLOR_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  lb_state_t         state;
  logic [ADDR_W-1:0] sweep;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [PIX_W-1:0]  pa_video;
  logic              rd_valid;
  logic              rd_bank;
  logic              do_write;
  logic              do_read;

  logic [ADDR_W-1:0] bank_addr  [2];
  logic              bank_we    [2];
  logic              bank_rd    [2];
  logic [PIX_W-1:0]  bank_wdata [2];
  logic [PIX_W-1:0]  bank_rdata [2];

  // Transparent sprite pixels still advance the pointer but skip the RAM.
  assign do_write = (state == RUN) && !WR_LD && WR_EN && (WR_COLOR != '0);
  assign do_read  = (state == RUN) && CLK_EN_PIX && !RD_LD && RD_RUN;

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_addr[b]  = '0;
      bank_we[b]    = 1'b0;
      bank_rd[b]    = 1'b0;
      bank_wdata[b] = '0;
    end
    if (state == INIT) begin
      for (int b = 0; b < 2; b++) begin
        bank_addr[b] = sweep;
        bank_we[b]   = 1'b1;
      end
    end else begin
      bank_addr[TMS]   = rd_ptr;
      bank_rd[TMS]     = do_read;
      bank_we[TMS]     = do_read && (CLEAR_ON_READ != 0);
      bank_addr[~TMS]  = wr_ptr;
      bank_we[~TMS]    = do_write;
      bank_wdata[~TMS] = {WR_PAL, WR_COLOR};
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    lb_bank_ram #(
      .ADDR_W(ADDR_W),
      .DATA_W(PIX_W)
    ) u_ram (
      .clk  (CLK),
      .addr (bank_addr[b]),
      .we   (bank_we[b]),
      .rd_en(bank_rd[b]),
      .wdata(bank_wdata[b]),
      .rdata(bank_rdata[b])
    );
  end

  // rd_bank remembers which bank was read so a TMS flip cannot redirect data in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= INIT;
      sweep    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pa_video <= '0;
      rd_valid <= 1'b0;
      rd_bank  <= 1'b0;
      READY    <= 1'b0;
    end else begin
      READY <= (state == RUN);
      case (state)
        INIT: begin
          sweep <= sweep + ADDR_W'(1);
          if (sweep == LAST_ADDR) state <= RUN;
          if (CLK_EN_PIX) rd_valid <= 1'b0;
        end
        RUN: begin
          if (WR_LD)      wr_ptr <= WR_ADDR;
          else if (WR_EN) wr_ptr <= WR_DIR ? wr_ptr - ADDR_W'(1) : wr_ptr + ADDR_W'(1);
          if (RD_LD)        rd_ptr <= RD_ADDR;
          else if (do_read) rd_ptr <= rd_ptr + ADDR_W'(1);
          if (CLK_EN_PIX) begin
            rd_valid <= do_read;
            rd_bank  <= TMS;
            if (BLANK)                            pa_video <= '0;
            else if (FIX_EN && FIX_COLOR != '0)  pa_video <= PIX_W'({FIX_PAL, FIX_COLOR});
            else if (rd_valid)                    pa_video <= bank_rdata[rd_bank];
            else                                  pa_video <= '0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  assign PA = CPU_SEL ? CPU_ADDR : pa_video;

endmodule

// File: tb/tb_neo_lb_mixer.sv
// Directed bench for neo_lb_mixer: one clear-on-read instance and one
// keep-on-read instance driven by the same stimulus.
module tb_neo_lb_mixer;

  typedef logic [11:0] pa4_t [4];

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CLK_EN_PIX = 1'b0;
  logic        TMS = 1'b0;
  logic        WR_LD = 1'b0;
  logic [8:0]  WR_ADDR = '0;
  logic        WR_DIR = 1'b0;
  logic        WR_EN = 1'b0;
  logic [7:0]  WR_PAL = '0;
  logic [3:0]  WR_COLOR = '0;
  logic        RD_LD = 1'b0;
  logic [8:0]  RD_ADDR = '0;
  logic        RD_RUN = 1'b0;
  logic [3:0]  FIX_COLOR = '0;
  logic [3:0]  FIX_PAL = '0;
  logic        FIX_EN = 1'b0;
  logic        BLANK = 1'b0;
  logic        CPU_SEL = 1'b0;
  logic [11:0] CPU_ADDR = '0;
  logic [11:0] PA, PA_nc;
  logic        READY, READY_nc;

  int checks = 0;
  int errors = 0;
  int n_cyc, pa_bad;

  always #5 CLK = ~CLK;

  neo_lb_mixer #(.ADDR_W(9), .PAL_W(8), .COLOR_W(4), .FIX_PAL_W(4), .CLEAR_ON_READ(1)) dut (
    .CLK(CLK), .RST(RST), .CLK_EN_PIX(CLK_EN_PIX), .TMS(TMS), .WR_LD(WR_LD),
    .WR_ADDR(WR_ADDR), .WR_DIR(WR_DIR), .WR_EN(WR_EN), .WR_PAL(WR_PAL),
    .WR_COLOR(WR_COLOR), .RD_LD(RD_LD), .RD_ADDR(RD_ADDR), .RD_RUN(RD_RUN),
    .FIX_COLOR(FIX_COLOR), .FIX_PAL(FIX_PAL), .FIX_EN(FIX_EN), .BLANK(BLANK),
    .CPU_SEL(CPU_SEL), .CPU_ADDR(CPU_ADDR), .PA(PA), .READY(READY)
  );

  neo_lb_mixer #(.ADDR_W(9), .PAL_W(8), .COLOR_W(4), .FIX_PAL_W(4), .CLEAR_ON_READ(0)) dut_nc (
    .CLK(CLK), .RST(RST), .CLK_EN_PIX(CLK_EN_PIX), .TMS(TMS), .WR_LD(WR_LD),
    .WR_ADDR(WR_ADDR), .WR_DIR(WR_DIR), .WR_EN(WR_EN), .WR_PAL(WR_PAL),
    .WR_COLOR(WR_COLOR), .RD_LD(RD_LD), .RD_ADDR(RD_ADDR), .RD_RUN(RD_RUN),
    .FIX_COLOR(FIX_COLOR), .FIX_PAL(FIX_PAL), .FIX_EN(FIX_EN), .BLANK(BLANK),
    .CPU_SEL(CPU_SEL), .CPU_ADDR(CPU_ADDR), .PA(PA_nc), .READY(READY_nc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pix();
    CLK_EN_PIX = 1'b1;
    tick();
    CLK_EN_PIX = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [3:0] color);
    WR_EN = 1'b1;
    WR_COLOR = color;
    tick();
    WR_EN = 1'b0;
  endtask

  task automatic wait_ready(output int n, output int bad);
    n = 0;
    bad = 0;
    while (!(READY && READY_nc) && n < 600) begin
      tick();
      n++;
      if (PA !== 12'h000 || PA_nc !== 12'h000) bad++;
    end
  endtask

  // Load, run four reads, then one idle pulse that must deliver zero.
  task automatic scan(input string tag, input logic [8:0] start, input pa4_t e, input pa4_t e_nc);
    RD_ADDR = start;
    RD_LD = 1'b1;
    pix();
    RD_LD = 1'b0;
    RD_RUN = 1'b1;
    pix();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) RD_RUN = 1'b0;
      pix();
      check($sformatf("%s_pa%0d", tag, i), PA, e[i]);
      check($sformatf("%s_nc_pa%0d", tag, i), PA_nc, e_nc[i]);
    end
    pix();
    check($sformatf("%s_tail", tag), PA, 12'h000);
  endtask

  initial begin
    tick();
    tick();
    check("rst_pa", PA, 12'h000);
    check("rst_ready", READY, 1'b0);
    CPU_SEL = 1'b1;
    CPU_ADDR = 12'h123;
    #1;
    check("rst_cpu_pa", PA, 12'h123);
    CPU_SEL = 1'b0;
    tick();

    RST = 1'b0;
    wait_ready(n_cyc, pa_bad);
    check("init_cycles", n_cyc, 513);
    check("init_pa_zero", pa_bad, 0);

    WR_ADDR = 9'h010;
    WR_LD = 1'b1;
    tick();
    WR_LD = 1'b0;
    WR_PAL = 8'h3A;
    wr(4'h1);
    wr(4'h0);
    wr(4'h5);
    wr(4'hF);

    WR_ADDR = 9'h001;
    WR_LD = 1'b1;
    tick();
    WR_LD = 1'b0;
    WR_DIR = 1'b1;
    WR_PAL = 8'h5C;
    wr(4'h1);
    wr(4'h2);
    wr(4'h3);
    wr(4'h4);
    WR_DIR = 1'b0;

    TMS = 1'b1;
    tick();
    scan("scan1", 9'h010, '{12'h3A1, 12'h000, 12'h3A5, 12'h3AF}, '{12'h3A1, 12'h000, 12'h3A5, 12'h3AF});
    scan("rescan", 9'h010, '{12'h000, 12'h000, 12'h000, 12'h000}, '{12'h3A1, 12'h000, 12'h3A5, 12'h3AF});
    scan("hflip", 9'h1FE, '{12'h5C4, 12'h5C3, 12'h5C2, 12'h5C1}, '{12'h5C4, 12'h5C3, 12'h5C2, 12'h5C1});

    WR_ADDR = 9'h023;
    WR_LD = 1'b1;
    tick();
    WR_ADDR = 9'h020;
    WR_EN = 1'b1;
    WR_PAL = 8'h3A;
    WR_COLOR = 4'h9;
    tick();
    WR_LD = 1'b0;
    WR_EN = 1'b0;
    wr(4'h5);
    wr(4'h5);
    wr(4'h5);
    TMS = 1'b0;
    tick();

    RD_ADDR = 9'h020;
    RD_LD = 1'b1;
    pix();
    RD_LD = 1'b0;
    RD_RUN = 1'b1;
    pix();
    FIX_EN = 1'b1;
    FIX_COLOR = 4'h7;
    FIX_PAL = 4'h2;
    pix();
    check("fix_over_sprite", PA, 12'h027);
    FIX_COLOR = 4'h0;
    pix();
    check("fix_transparent", PA, 12'h3A5);
    CPU_SEL = 1'b1;
    CPU_ADDR = 12'hABC;
    #1;
    check("cpu_immediate", PA, 12'hABC);
    tick();
    check("cpu_hold", PA, 12'hABC);
    CPU_SEL = 1'b0;
    #1;
    check("cpu_release", PA, 12'h3A5);
    BLANK = 1'b1;
    pix();
    check("blank", PA, 12'h000);
    BLANK = 1'b0;
    RD_RUN = 1'b0;
    pix();
    check("ld_over_en", PA, 12'h000);
    check("ld_over_en_nc", PA_nc, 12'h000);

    RD_ADDR = 9'h020;
    RD_LD = 1'b1;
    pix();
    RD_LD = 1'b0;
    RD_RUN = 1'b1;
    FIX_COLOR = 4'h3;
    FIX_PAL = 4'h1;
    pix();
    pix();
    check("mid_fix", PA, 12'h013);
    FIX_EN = 1'b0;
    pix();
    check("mid_sprite_nc", PA_nc, 12'h3A5);
    RST = 1'b1;
    #1;
    check("midrst_pa", PA, 12'h000);
    check("midrst_ready", READY, 1'b0);
    check("midrst_nc_pa", PA_nc, 12'h000);
    RD_RUN = 1'b0;
    tick();
    RST = 1'b0;
    wait_ready(n_cyc, pa_bad);
    check("reinit_cycles", n_cyc, 513);
    check("reinit_pa_zero", pa_bad, 0);
    scan("after_rst", 9'h020, '{12'h000, 12'h000, 12'h000, 12'h000}, '{12'h000, 12'h000, 12'h000, 12'h000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
